// File: rtl/tdc_calib_axil_pkg.sv
// Shared constants and types for the TDC calibration AXI4-Lite register slave.
package tdc_calib_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] REG0_OFFS = 4'h0;
  localparam logic [3:0] REG1_OFFS = 4'h4;
  localparam logic [3:0] REG2_OFFS = 4'h8;
  localparam logic [3:0] REG3_OFFS = 4'hC;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = strb[b] ? wd[8*b +: 8] : cur[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/tdc_calib_axil_wjoin.sv
// Joins the independent AW and W channels into a single commit strobe.
module tdc_calib_axil_wjoin
  import tdc_calib_axil_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            idle_i,
  input  logic            done_i,
  input  logic [AW-1:0]   awaddr_i,
  input  logic            awvalid_i,
  output logic            awready_o,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic            wvalid_i,
  output logic            wready_o,
  output logic            commit_o,
  output logic [AW-1:0]   addr_o,
  output logic [DW-1:0]   data_o,
  output logic [DW/8-1:0] strb_o
);

  logic            aw_held_q, w_held_q, aw_rdy_q, w_rdy_q;
  logic            aw_held_d, w_held_d, aw_hs, w_hs;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic [DW/8-1:0] strb_q;

  assign aw_hs     = awvalid_i & aw_rdy_q;
  assign w_hs      = wvalid_i & w_rdy_q;
  assign aw_held_d = ~done_i & (aw_held_q | aw_hs);
  assign w_held_d  = ~done_i & (w_held_q | w_hs);

  // A handshake on this edge counts as held, so the last one commits immediately.
  assign commit_o  = idle_i & (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign addr_o    = aw_held_q ? addr_q : awaddr_i;
  assign data_o    = w_held_q ? data_q : wdata_i;
  assign strb_o    = w_held_q ? strb_q : wstrb_i;
  assign awready_o = aw_rdy_q;
  assign wready_o  = w_rdy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_rdy_q  <= 1'b0;
      w_rdy_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_rdy_q  <= ~aw_held_d;
      w_rdy_q   <= ~w_held_d;
      if (aw_hs) addr_q <= awaddr_i;
      if (w_hs) begin
        data_q <= wdata_i;
        strb_q <= wstrb_i;
      end
    end
  end

endmodule

// File: rtl/tdc_calib_axil_slave.sv
// AXI4-Lite slave exposing four TDC calibration registers with per-register write pulses.
// Optional TDC_AXIL_SLVERR_EN: out-of-range addresses get SLVERR instead of aliasing.
module tdc_calib_axil_slave
  import tdc_calib_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o,
  output logic [3:0]                      reg_wr_o
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;

  wstate_t             wstate_q;
  rstate_t             rstate_q;
  logic [3:0][DW-1:0]  regs_q;
  logic [3:0]          reg_wr_q;
  logic                bvalid_q, rvalid_q, arready_q;
  logic [1:0]          bresp_q, rresp_q;
  logic [DW-1:0]       rdata_q;

  logic                commit, wr_oor, rd_oor, unused_bits;
  logic [AW-1:0]       c_addr;
  logic [DW-1:0]       c_data;
  logic [DW/8-1:0]     c_strb;
  logic [1:0]          wr_sel, rd_sel;

  tdc_calib_axil_wjoin #(.AW(AW), .DW(DW)) u_wjoin (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .idle_i    (wstate_q == W_IDLE),
    .done_i    ((wstate_q == W_RESP) && S_AXI_BREADY),
    .awaddr_i  (S_AXI_AWADDR),
    .awvalid_i (S_AXI_AWVALID),
    .awready_o (S_AXI_AWREADY),
    .wdata_i   (S_AXI_WDATA),
    .wstrb_i   (S_AXI_WSTRB),
    .wvalid_i  (S_AXI_WVALID),
    .wready_o  (S_AXI_WREADY),
    .commit_o  (commit),
    .addr_o    (c_addr),
    .data_o    (c_data),
    .strb_o    (c_strb)
  );

  assign wr_sel = c_addr[3:2];
  assign rd_sel = S_AXI_ARADDR[3:2];

`ifdef TDC_AXIL_SLVERR_EN
  assign wr_oor      = |c_addr[AW-1:4];
  assign rd_oor      = |S_AXI_ARADDR[AW-1:4];
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, c_addr[1:0], S_AXI_ARADDR[1:0]};
`else
  assign wr_oor      = 1'b0;
  assign rd_oor      = 1'b0;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, c_addr[AW-1:4], c_addr[1:0],
                         S_AXI_ARADDR[AW-1:4], S_AXI_ARADDR[1:0]};
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q <= W_IDLE;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      regs_q   <= '0;
      reg_wr_q <= '0;
    end else begin
      reg_wr_q <= '0;
      case (wstate_q)
        W_IDLE: if (commit) begin
          wstate_q <= W_RESP;
          bvalid_q <= 1'b1;
          if (wr_oor) begin
            bresp_q <= RESP_SLVERR;
          end else begin
            bresp_q          <= RESP_OKAY;
            regs_q[wr_sel]   <= strb_merge(regs_q[wr_sel], c_data, c_strb);
            reg_wr_q[wr_sel] <= 1'b1;
          end
        end
        W_RESP: if (S_AXI_BREADY) begin
          wstate_q <= W_IDLE;
          bvalid_q <= 1'b0;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read samples regs_q before any same-edge write lands, so it sees the old value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (S_AXI_ARVALID && arready_q) begin
            rstate_q  <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_oor ? '0 : regs_q[rd_sel];
            rresp_q   <= rd_oor ? RESP_SLVERR : RESP_OKAY;
          end
        end
        R_DATA: if (S_AXI_RREADY) begin
          rstate_q  <= R_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign regs_o        = regs_q;
  assign reg_wr_o      = reg_wr_q;

endmodule

// File: tb/tb_tdc_calib_axil_slave.sv
// Self-checking bench for tdc_calib_axil_slave; read data is checked by a queue scoreboard.
module tb_tdc_calib_axil_slave;

  logic         ACLK, ARESET;
  logic [5:0]   S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]   S_AXI_AWPROT, S_AXI_ARPROT;
  logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0]  S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]   S_AXI_WSTRB, reg_wr_o;
  logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
  logic         S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic         S_AXI_RVALID, S_AXI_RREADY;
  logic [127:0] regs_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {logic [31:0] d; logic [1:0] r;} exp_t;
  exp_t exp_q[$];

  tdc_calib_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .regs_o(regs_o), .reg_wr_o(reg_wr_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Scoreboard: every completed R handshake pops one expected entry.
  always @(negedge ACLK) begin
    if (!ARESET && S_AXI_RVALID && S_AXI_RREADY) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got data=%h resp=%b, no read expected", S_AXI_RDATA, S_AXI_RRESP);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (S_AXI_RDATA !== e.d || S_AXI_RRESP !== e.r) begin
          errors++;
          $display("FAIL rd_data: got %h/%b, expected %h/%b", S_AXI_RDATA, S_AXI_RRESP, e.d, e.r);
        end
      end
    end
  end

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [3:0] wr);
    logic ag, wg, got;
    resp = 2'bxx; wr = 4'bxxxx; got = 1'b0;
    @(posedge ACLK); #1;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      ag = S_AXI_AWVALID && S_AXI_AWREADY;
      wg = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (ag) S_AXI_AWVALID = 1'b0;
      if (wg) S_AXI_WVALID = 1'b0;
      if (!S_AXI_AWVALID && !S_AXI_WVALID) break;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) begin
        resp = S_AXI_BRESP; wr = reg_wr_o; got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wr_timeout: addr=%h got no BVALID, expected BVALID within 20 cycles", a);
    end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [31:0] ed, input logic [1:0] er);
    logic go, got;
    go = 1'b0; got = 1'b0;
    @(posedge ACLK); #1;
    exp_q.push_back('{d: ed, r: er});
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    for (int i = 0; i < 20 && !go; i++) begin
      @(negedge ACLK);
      go = S_AXI_ARREADY;
      @(posedge ACLK); #1;
    end
    S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 20 && go; i++) begin
      @(negedge ACLK);
      if (S_AXI_RVALID) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      exp_q.delete();
      $display("FAIL rd_timeout: addr=%h got no RVALID, expected RVALID within 20 cycles", a);
    end
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_AWPROT = '0; S_AXI_ARPROT = '0;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_BREADY = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
      errors++; $display("FAIL rst_handshake: got %b, expected 00000",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
    end
    checks++;
    if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, reg_wr_o} !== 40'h0 || regs_o !== 128'h0) begin
      errors++; $display("FAIL rst_outputs: got rdata=%h regs=%h wr=%b, expected zeros",
        S_AXI_RDATA, regs_o, reg_wr_o);
    end
    @(posedge ACLK); #1; ARESET = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      errors++; $display("FAIL rst_ready_early: got %b, expected 000 before first edge",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      errors++; $display("FAIL rst_ready: got %b, expected 111 after first edge",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
  endtask

  task automatic test_basic();
    logic [31:0] vals [4];
    logic [1:0] resp; logic [3:0] wr;
    vals[0] = 32'h0101FFFF; vals[1] = 32'hABCD0001; vals[2] = 32'hDEAD0011; vals[3] = 32'hBEEF0011;
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(4*i), vals[i], 4'hF, resp, wr);
      checks++;
      if (resp !== 2'b00 || wr !== 4'(1 << i)) begin
        errors++; $display("FAIL basic_wr%0d: got resp=%b wr=%b, expected 00/%b", i, resp, wr, 4'(1 << i));
      end
    end
    for (int i = 0; i < 4; i++) axi_read(6'(4*i), vals[i], 2'b00);
    checks++;
    if (regs_o !== {vals[3], vals[2], vals[1], vals[0]}) begin
      errors++; $display("FAIL basic_regs: got %h, expected %h", regs_o, {vals[3], vals[2], vals[1], vals[0]});
    end
  endtask

  task automatic test_strb();
    logic [1:0] resp; logic [3:0] wr;
    axi_write(6'h4, 32'hFFFFFFFF, 4'hF, resp, wr);
    axi_write(6'h4, 32'h12345678, 4'b0101, resp, wr);
    axi_read(6'h4, 32'hFF34FF78, 2'b00);
    axi_write(6'h4, 32'h00000000, 4'b0000, resp, wr);
    checks++;
    if (resp !== 2'b00 || wr !== 4'b0010) begin
      errors++; $display("FAIL strb0_wr: got resp=%b wr=%b, expected 00/0010", resp, wr);
    end
    axi_read(6'h4, 32'hFF34FF78, 2'b00);
  endtask

  task automatic test_order();
    // AW leads W by three cycles, then W leads AW.
    for (int pass = 0; pass < 2; pass++) begin
      logic [31:0] d; logic [5:0] a; logic [3:0] ewr;
      a = pass == 0 ? 6'hC : 6'h8;
      d = pass == 0 ? 32'h0000C0DE : 32'h00000011;
      ewr = pass == 0 ? 4'b1000 : 4'b0100;
      @(posedge ACLK); #1;
      S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = 4'hF; S_AXI_BREADY = 1'b0;
      if (pass == 0) S_AXI_AWVALID = 1'b1; else S_AXI_WVALID = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      @(negedge ACLK);
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== (pass == 0 ? 3'b010 : 3'b100)) begin
        errors++; $display("FAIL order%0d_held: got aw/w/b=%b, expected %b", pass,
          {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, (pass == 0 ? 3'b010 : 3'b100));
      end
      repeat (2) @(posedge ACLK);
      #1;
      if (pass == 0) S_AXI_WVALID = 1'b1; else S_AXI_AWVALID = 1'b1;
      @(negedge ACLK);
      checks++;
      if (S_AXI_BVALID !== 1'b0 || reg_wr_o !== 4'b0) begin
        errors++; $display("FAIL order%0d_early: got b=%b wr=%b, expected 0/0000", pass, S_AXI_BVALID, reg_wr_o);
      end
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      @(negedge ACLK);
      checks++;
      if (S_AXI_BVALID !== 1'b1 || reg_wr_o !== ewr || regs_o[32*a[3:2] +: 32] !== d) begin
        errors++; $display("FAIL order%0d_commit: got b=%b wr=%b reg=%h, expected 1/%b/%h", pass,
          S_AXI_BVALID, reg_wr_o, regs_o[32*a[3:2] +: 32], ewr, d);
      end
      S_AXI_BREADY = 1'b1;
      @(posedge ACLK); #1; S_AXI_BREADY = 1'b0;
      @(negedge ACLK);
      checks++;
      if ({S_AXI_BVALID, reg_wr_o, S_AXI_AWREADY, S_AXI_WREADY} !== 7'b0000011) begin
        errors++; $display("FAIL order%0d_done: got b/wr/aw/w=%b, expected 0000011", pass,
          {S_AXI_BVALID, reg_wr_o, S_AXI_AWREADY, S_AXI_WREADY});
      end
    end
  endtask

  task automatic test_back_to_back();
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 6'h0; S_AXI_WDATA = 32'h11112222; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    @(posedge ACLK); #1;
    S_AXI_WDATA = 32'h33334444;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP} !== 5'b00100 ||
          regs_o[31:0] !== 32'h11112222) begin
        errors++; $display("FAIL bp_stall%0d: got aw/w/b/resp=%b reg0=%h, expected 00100/11112222", i,
          {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP}, regs_o[31:0]);
      end
      @(posedge ACLK);
    end
    #1; S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1; S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== 3'b110) begin
      errors++; $display("FAIL bp_release: got aw/w/b=%b, expected 110", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID});
    end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    checks++;
    if (S_AXI_BVALID !== 1'b1 || reg_wr_o !== 4'b0001 || regs_o[31:0] !== 32'h33334444) begin
      errors++; $display("FAIL bp_second: got b=%b wr=%b reg0=%h, expected 1/0001/33334444",
        S_AXI_BVALID, reg_wr_o, regs_o[31:0]);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1; S_AXI_BREADY = 1'b0;
  endtask

  task automatic test_collision();
    @(posedge ACLK); #1;
    exp_q.push_back('{d: 32'h00000011, r: 2'b00});
    S_AXI_AWADDR = 6'h8; S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 6'h8;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    checks++;
    if (S_AXI_BVALID !== 1'b1 || S_AXI_RVALID !== 1'b1 || regs_o[95:64] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL coll_state: got b=%b r=%b reg2=%h, expected 1/1/a5a5a5a5",
        S_AXI_BVALID, S_AXI_RVALID, regs_o[95:64]);
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    axi_read(6'h8, 32'hA5A5A5A5, 2'b00);
  endtask

  task automatic test_midreset();
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 6'h4; S_AXI_WDATA = 32'h00000055; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 6'h4;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11 || regs_o[63:32] !== 32'h55) begin
      errors++; $display("FAIL mr_pending: got b/r=%b reg1=%h, expected 11/00000055",
        {S_AXI_BVALID, S_AXI_RVALID}, regs_o[63:32]);
    end
    ARESET = 1'b1;
    #1;
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 5'b0 ||
        regs_o !== 128'h0) begin
      errors++; $display("FAIL mr_abort: got b/r/aw/w/ar=%b regs=%h, expected 00000/0",
        {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, regs_o);
    end
    @(posedge ACLK); #1; ARESET = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b11100) begin
      errors++; $display("FAIL mr_recover: got %b, expected 11100",
        {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
    end
    axi_read(6'h4, 32'h0, 2'b00);
  endtask

  task automatic test_alias();
    logic [1:0] resp; logic [3:0] wr;
    axi_write(6'h10, 32'hCAFEF00D, 4'hF, resp, wr);
`ifdef TDC_AXIL_SLVERR_EN
    checks++;
    if (resp !== 2'b10 || wr !== 4'b0000 || regs_o !== 128'h0) begin
      errors++; $display("FAIL oor_wr: got resp=%b wr=%b regs=%h, expected 10/0000/0", resp, wr, regs_o);
    end
    axi_read(6'h0, 32'h0, 2'b00);
    axi_read(6'h10, 32'h0, 2'b10);
`else
    checks++;
    if (resp !== 2'b00 || wr !== 4'b0001 || regs_o[31:0] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL alias_wr: got resp=%b wr=%b reg0=%h, expected 00/0001/cafef00d",
        resp, wr, regs_o[31:0]);
    end
    axi_read(6'h0, 32'hCAFEF00D, 2'b00);
    axi_read(6'h10, 32'hCAFEF00D, 2'b00);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strb();
    test_order();
    test_back_to_back();
    test_collision();
    test_midreset();
    test_alias();
    repeat (2) @(posedge ACLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdc_calib_axil_slave.md
# tdc_calib_axil_slave

AXI4-Lite responder providing the four 32-bit calibration control registers of the TDC calibration capture block. Sits on the S00_AXI port and answers the AXI4-Lite master on the bus. Register contents are exported to the capture datapath, with a one-cycle write pulse per register.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32: data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 6: byte address width; bits [3:2] select the register.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  ADDR_W  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- regs_o  out  128  {reg3, reg2, reg1, reg0}.
- reg_wr_o  out  4  one-cycle pulse per register on commit.

## Operation
- Four read/write registers at offsets 0x0, 0x4, 0x8 and 0xC. Reset value of every register is 0.
- Write FSM states:
  - W_IDLE: AWREADY = !aw_held and WREADY = !w_held. AW and W are accepted independently, in either order or in the same cycle, and each is latched.
  - Commit: on the edge where both AW and W are held, the write is committed with byte-wise WSTRB merge, reg_wr_o[sel] pulses for one cycle, and the FSM moves to W_RESP.
  - W_RESP: BVALID = 1, AWREADY = WREADY = 0. On BVALID && BREADY, clear the held flags and return to W_IDLE.
- Read FSM states:
  - R_IDLE: ARREADY = 1. On ARVALID, RDATA and RRESP are captured from the register contents at that edge; move to R_DATA.
  - R_DATA: RVALID = 1, ARREADY = 0. On RREADY, return to R_IDLE.
- One outstanding write and one outstanding read; both channels run concurrently.
- Simultaneous write commit and read capture on the same register in the same edge: the read returns the pre-write value.
- READY outputs depend only on registered state, never on the VALID inputs.
- RDATA and RRESP hold stable while RVALID = 1 and RREADY = 0. BRESP holds stable while BVALID = 1.
- WSTRB = 0 still completes the handshake and pulses reg_wr_o, but changes no register.

## Timing
- While ARESET is high:
  - all READY and VALID outputs are 0;
  - BRESP, RRESP, RDATA, regs_o and reg_wr_o are 0;
  - both FSMs are in their IDLE state.
- First READY is asserted on the first ACLK edge after ARESET deasserts.
- Write latency: the last AW/W handshake at edge N gives a register update and BVALID after edge N; the new value is visible on regs_o after edge N.
- Read latency: the AR handshake at edge N gives RVALID after edge N.
- Back-to-back throughput: one write every 2 cycles and one read every 2 cycles when BREADY and RREADY are held high.
- ARESET asserted mid-transaction: the transaction is abandoned immediately with no response, and registers return to 0.

## Configuration
- TDC_AXIL_SLVERR_EN defined:
  - an address with any bit above [3:2] nonzero is out of range;
  - an out-of-range write commits nothing, gives no reg_wr_o pulse and returns BRESP = SLVERR (2'b10);
  - an out-of-range read returns RDATA = 0 with RRESP = SLVERR.
- TDC_AXIL_SLVERR_EN undefined: only bits [3:2] are decoded, higher addresses alias onto the four registers, and every response is OKAY (2'b00).

## Structure
- Package tdc_calib_axil_pkg holds:
  - the response codes RESP_OKAY and RESP_SLVERR;
  - the register offset constants;
  - the typedefs for the write and read FSM states.
- Optional sub-module tdc_calib_axil_wjoin: holds the AW/W latches and held flags, and presents a single "write ready to commit" strobe with address, data and strobe. The read path stays inline.

## Test plan
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x0 through 0xC, then read each back -> data matches, all responses OKAY, reg_wr_o pulses bits 0 to 3 in turn.
- Write 0xFFFFFFFF to 0x4, then write 0x12345678 with WSTRB = 4'b0101 -> readback 0xFF34FF78.
- AWVALID asserted 3 cycles before WVALID, then the reverse order -> each write commits exactly once, and BVALID rises one cycle after the later handshake.
- BREADY held low 5 cycles with a second AW/W pending -> AWREADY = WREADY = 0 throughout, BRESP stable, second write accepted after the B handshake.
- Same-edge write of 0xA5A5A5A5 and read of 0x8, which previously held 0x11 -> read returns 0x11, and a subsequent read returns 0xA5A5A5A5.
- ARESET pulsed while in W_RESP and R_DATA -> BVALID = RVALID = 0 and regs_o = 0 immediately. With TDC_AXIL_SLVERR_EN, write to 0x10 -> SLVERR and registers unchanged; without it -> 0x10 aliases to reg0.
